// File: rtl/fifo_producer.sv
// fifo_producer: write-side buffer and strobe generator for the async FIFO.
// Optional rejected-request counter enabled by FIFO_PRODUCER_DROP_CNT_EN.
module fifo_producer #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int AW = $clog2(BUF_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                  w_clk,
  input  logic                  wrst,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  wr_ready,
  input  logic                  f_full,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [LW-1:0]         buf_level,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  idle
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    STALL
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [LW-1:0]         next_level;
  logic                  push;
  logic                  pop;

  // Readiness looks only at current occupancy; a pop never frees a slot early.
  assign wr_ready = (buf_level < LW'(BUF_DEPTH));
  assign push     = wr_req && wr_ready;
  assign pop      = (buf_level != '0) && !f_full;

  always_comb begin
    next_level = buf_level;
    case ({push, pop})
      2'b10:   next_level = buf_level + LW'(1);
      2'b01:   next_level = buf_level - LW'(1);
      default: next_level = buf_level;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (push) begin
      mem[wptr] <= data_in;
    end
  end

  always_ff @(posedge w_clk or posedge wrst) begin
    if (wrst) begin
      wptr        <= '0;
      rptr        <= '0;
      buf_level   <= '0;
      w_en        <= 1'b0;
      mem_data_in <= '0;
      wr_count    <= '0;
      state       <= IDLE;
      idle        <= 1'b1;
    end else begin
      w_en      <= pop;
      buf_level <= next_level;
      if (pop) begin
        mem_data_in <= mem[rptr];
        rptr        <= rptr + AW'(1);
      end
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (w_en) begin
        wr_count <= wr_count + CNT_WIDTH'(1);
      end
      // State follows post-edge occupancy and the sampled full flag.
      case (state)
        IDLE: begin
          if (push) begin
            state <= ACTIVE;
            idle  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (next_level == '0) begin
            state <= IDLE;
            idle  <= 1'b1;
          end else if (f_full) begin
            state <= STALL;
          end
        end
        STALL: begin
          if (!f_full) begin
            if (next_level == '0) begin
              state <= IDLE;
              idle  <= 1'b1;
            end else begin
              state <= ACTIVE;
            end
          end
        end
        default: begin
          state <= IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIFO_PRODUCER_DROP_CNT_EN
  always_ff @(posedge w_clk or posedge wrst) begin
    if (wrst) begin
      drop_cnt <= '0;
    end else if (wr_req && !wr_ready && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_producer.sv
// tb_fifo_producer: queue-based reference model plus directed scenarios.
// Compare process runs on the falling edge; stimulus changes 1ns after rise.
module tb_fifo_producer;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int CW = 16;
  localparam int LW = $clog2(DEPTH) + 1;
`ifdef FIFO_PRODUCER_DROP_CNT_EN
  localparam int DROP_ON = 1;
`else
  localparam int DROP_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          f_full = 1'b0;
  logic          wr_ready;
  logic          w_en;
  logic [DW-1:0] mem_data_in;
  logic [LW-1:0] buf_level;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] drop_cnt;
  logic          idle;

  fifo_producer #(
    .DATA_WIDTH(DW),
    .BUF_DEPTH(DEPTH),
    .CNT_WIDTH(CW)
  ) dut (
    .w_clk(clk),
    .wrst(rst),
    .wr_req(wr_req),
    .data_in(data_in),
    .wr_ready(wr_ready),
    .f_full(f_full),
    .w_en(w_en),
    .mem_data_in(mem_data_in),
    .buf_level(buf_level),
    .wr_count(wr_count),
    .drop_cnt(drop_cnt),
    .idle(idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  bit armed = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a queue of accepted words plus the spec's counters.
  logic [DW-1:0] q[$];
  logic          m_wen = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [CW-1:0] m_cnt = '0;
  logic [CW-1:0] m_drop = '0;
  logic          m_idle = 1'b1;

  always @(posedge clk or posedge rst) begin
    int  n;
    bit  pu;
    bit  po;
    if (rst) begin
      q.delete();
      m_wen  = 1'b0;
      m_data = '0;
      m_cnt  = '0;
      m_drop = '0;
      m_idle = 1'b1;
    end else begin
      n  = q.size();
      pu = wr_req && (n < DEPTH);
      po = (n > 0) && !f_full;
      if (m_wen) m_cnt = m_cnt + 1'b1;
      if (DROP_ON != 0 && wr_req && n >= DEPTH && m_drop != '1)
        m_drop = m_drop + 1'b1;
      if (po) m_data = q.pop_front();
      m_wen = po;
      if (pu) q.push_back(data_in);
      m_idle = m_idle ? !pu : (q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (armed && !rst) begin
      chk("m_w_en", w_en, m_wen);
      chk("m_data", mem_data_in, m_data);
      chk("m_level", buf_level, q.size());
      chk("m_ready", wr_ready, q.size() < DEPTH);
      chk("m_count", wr_count, m_cnt);
      chk("m_drop", drop_cnt, m_drop);
      chk("m_idle", idle, m_idle);
    end
  end

  bit            collect = 0;
  logic [DW-1:0] emitted[$];
  int            wen_seen = 0;

  always @(negedge clk) begin
    if (collect && w_en) emitted.push_back(mem_data_in);
    if (w_en) wen_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_req = 1'b0;
    f_full = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_w_en", w_en, 0);
    chk("rst_level", buf_level, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ready", wr_ready, 1);
  endtask

  int next_val;
  int seen0;

  initial begin
    do_reset();
    armed = 1;

    // Single word: strobe two edges after presentation.
    wr_req = 1'b1;
    data_in = 32'hA5A5_0001;
    step();
    wr_req = 1'b0;
    chk("t1_level", buf_level, 1);
    chk("t1_no_wen", w_en, 0);
    step();
    chk("t1_wen", w_en, 1);
    chk("t1_data", mem_data_in, 32'hA5A5_0001);
    step();
    chk("t1_wen_off", w_en, 0);
    chk("t1_count", wr_count, 1);
    chk("t1_idle", idle, 1);

    // Burst fill while the FIFO is full.
    do_reset();
    f_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1;
      data_in = 32'h10 + i;
      step();
    end
    data_in = 32'h14;
    chk("t2_ready", wr_ready, 0);
    chk("t2_level", buf_level, 4);
    step();
    wr_req = 1'b0;
    chk("t2_level2", buf_level, 4);
    chk("t2_no_wen", w_en, 0);
    chk("t2_idle", idle, 0);
    chk("t2_drop", drop_cnt, DROP_ON);

    // Release full: four back-to-back writes in order.
    f_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_wen", w_en, 1);
      chk("t3_data", mem_data_in, 32'h10 + i);
    end
    step();
    chk("t3_wen_off", w_en, 0);
    chk("t3_level", buf_level, 0);
    chk("t3_idle", idle, 1);
    chk("t3_count", wr_count, 4);

    // Streaming with toggling back-pressure and a proper handshake.
    emitted.delete();
    collect = 1;
    next_val = 32'h100;
    for (int i = 0; i < 20; i++) begin
      bit acc;
      wr_req = 1'b1;
      data_in = next_val;
      f_full = (i % 2) == 1;
      acc = wr_ready;
      step();
      if (acc) next_val++;
    end
    wr_req = 1'b0;
    f_full = 1'b0;
    repeat (10) step();
    collect = 0;
    chk("t4_len", emitted.size(), next_val - 32'h100);
    chk("t4_min_len", emitted.size() >= 8, 1);
    foreach (emitted[j]) chk("t4_order", emitted[j], 32'h100 + j);

    // Push and pop at full occupancy.
    f_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1;
      data_in = 32'h20 + i;
      step();
    end
    f_full = 1'b0;
    data_in = 32'h55;
    chk("t5_ready", wr_ready, 0);
    step();
    chk("t5_level", buf_level, 3);
    chk("t5_data", mem_data_in, 32'h20);
    chk("t5_ready2", wr_ready, 1);
    step();
    wr_req = 1'b0;
    chk("t5_level2", buf_level, 3);
    chk("t5_data2", mem_data_in, 32'h21);
    repeat (6) step();
    chk("t5_last", mem_data_in, 32'h55);

    // Asynchronous reset mid-burst.
    f_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1;
      data_in = 32'h30 + i;
      step();
    end
    wr_req = 1'b0;
    f_full = 1'b0;
    step();
    chk("t6_pre_wen", w_en, 1);
    chk("t6_pre_level", buf_level, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_wen", w_en, 0);
    chk("t6_level", buf_level, 0);
    chk("t6_count", wr_count, 0);
    chk("t6_idle", idle, 1);
    step();
    rst = 1'b0;
    seen0 = wen_seen;
    repeat (6) step();
    chk("t6_no_residual", wen_seen - seen0, 0);
    chk("t6_level_after", buf_level, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_producer.md
Name: fifo_producer

Overview:
Write-side controller for the team's asynchronous FIFO, and the counterpart of the read-side consumer. Accepts words from an upstream source through a req/ready handshake and holds them in a small internal circular buffer. Drains the buffer into FIFO memory with registered w_en/mem_data_in pulses, throttled by the FIFO full flag. Everything runs in the write clock domain; pointer synchronisation stays in the FIFO core.

Parameters:
DATA_WIDTH, 32, width of data words
BUF_DEPTH, 4, internal buffer entries; power of 2, >= 2
CNT_WIDTH, 16, width of wr_count and drop_cnt

Ports:
w_clk  input  1  write-domain clock, rising edge
wrst  input  1  asynchronous reset, active-high
wr_req  input  1  upstream presents data_in this cycle
data_in  input  DATA_WIDTH  upstream write data
wr_ready  output  1  buffer can accept a word (combinational from occupancy)
f_full  input  1  FIFO full flag, already synchronised to w_clk
w_en  output  1  registered write strobe to FIFO memory
mem_data_in  output  DATA_WIDTH  registered write data to FIFO memory
buf_level  output  $clog2(BUF_DEPTH)+1  current buffer occupancy
wr_count  output  CNT_WIDTH  total words written to FIFO, wrapping
drop_cnt  output  CNT_WIDTH  rejected requests (optional feature)
idle  output  1  high in IDLE state

Behaviour:
- Clocking and reset: one clock, w_clk. Reset wrst is asynchronous and active-high.
- Reset values: w_en=0, mem_data_in=0, buf_level=0, wr_count=0, drop_cnt=0, state=IDLE, idle=1. Read/write pointers are 0.
- Reset mid-operation: buffered words are discarded. No w_en pulse follows reset release until a new word is accepted.
- wr_ready = (buf_level < BUF_DEPTH), taken from the current occupancy only.
  - A pop in the same cycle does not free a slot for a push. A request at full is rejected even if a pop happens that cycle.
- Push: occurs at a rising edge when wr_req && wr_ready. data_in is written at wptr, and wptr increments mod BUF_DEPTH.
- Pop: condition is buf_level>0 && !f_full, sampled at the edge.
  - On pop: w_en<=1, mem_data_in<=buf[rptr], rptr increments mod BUF_DEPTH.
  - Otherwise: w_en<=0 and mem_data_in holds its last value.
- Simultaneous push and pop: buf_level is unchanged and both pointers advance.
- Buffer empty with push in the same edge: no bypass; the pop decision uses the pre-edge level.
- Minimum latency: word accepted at edge k appears with w_en=1 after edge k+1, provided f_full is low at edge k+1.
- Ordering: strict FIFO. No word is duplicated or lost once accepted.
- f_full rising: the word at the head stays buffered. The strobe stops after the edge that samples f_full=1; no write is ever issued on an edge where f_full=1.
- wr_count increments on every edge where w_en is asserted (registered next cycle); it wraps at 2^CNT_WIDTH.
- FSM, evaluated on post-edge occupancy:
  - IDLE: buffer empty. Goes to ACTIVE on push.
  - ACTIVE: buffer non-empty, f_full=0. Goes to STALL when f_full=1. Goes to IDLE when the level reaches 0 with no push.
  - STALL: buffer non-empty, f_full=1. Goes to ACTIVE when f_full=0.
  - IDLE is never left without a push.

Optional Feature:
Macro: FIFO_PRODUCER_DROP_CNT_EN.
- Defined: drop_cnt increments on every edge with wr_req && !wr_ready, saturating at 2^CNT_WIDTH-1. It clears only on reset.
- Undefined: drop_cnt is tied to 0 and no counter logic is synthesised. The port list is identical in both builds.

Test Plan:
- Reset then single word: wr_req=1 with data_in=0xA5A5_0001 for one cycle, f_full=0. Expect w_en=1 for exactly one cycle, two edges after presentation, with mem_data_in=0xA5A5_0001. Afterwards wr_count=1, idle=1.
- Burst fill with f_full=1: push 0x10,0x11,0x12,0x13, then request 0x14. Expect wr_ready=0 at buf_level=4, 0x14 not accepted, no w_en pulses, state=STALL. With FIFO_PRODUCER_DROP_CNT_EN defined, drop_cnt=1.
- Release full: from the previous case drop f_full to 0. Expect four consecutive w_en pulses carrying 0x10..0x13 in order, then buf_level=0, idle=1, wr_count=4.
- Streaming with back-pressure: push every cycle while f_full toggles 1/0 each cycle for 20 cycles, data incrementing from 0x100. Expect the output sequence to be contiguous from 0x100 with no gaps or duplicates, and no w_en on any f_full=1 edge.
- Push and pop at full: buf_level=4, f_full=0, wr_req=1 with data 0x55. Expect the request rejected that cycle, one pop, buf_level=3; 0x55 accepted on the next edge.
- Reset mid-burst: assert wrst asynchronously with buf_level=3 and w_en high. Expect w_en=0, buf_level=0, wr_count=0 immediately; no residual words emitted after release.
